lsu_byte_sequencer: RTL

//   Load/store sequencer between the execute stage and a byte-wide data memory array.

---
 rtl/lsu_byte_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : lsu_byte_sequencer
//  Description: Load/store sequencer between the execute stage and a
//               byte-wide data memory. Takes one request at a time over a
//               valid/ready handshake, splits LB/LH/LW (SB/SH/SW) accesses
//               into little-endian byte beats, reassembles load bytes and
//               sign/zero-extends them, then emits a one-cycle response.
//
//  Ports      : clk, rst_n            clock, asynchronous active-low reset
//               req_valid/req_ready   request handshake
//               req_we, req_func3     store flag, RV32 funct3 size/sign code
//               req_addr, req_wdata   byte address, store data
//               rsp_valid             one-cycle response pulse
//               rsp_rdata, rsp_err    extended load data, error flag
//               mem_en, mem_we        byte beat strobe, beat is a write
//               mem_addr, mem_wdata   beat byte address, beat write byte
//               mem_rdata             read byte, valid the cycle after a read
//
//  Config     : `define MISALIGN_TRAP_EN to trap misaligned halfword/word
//               accesses instead of serialising them bytewise.
//
//  Revision   : 1.0  initial release
// ============================================================================
module lsu_byte_sequencer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_LAST = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [2:0]          r_func3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [1:0]          r_idx;
    logic [1:0]          r_last_idx;
    logic [31:0]         r_rdata;

    logic                w_accept;
    logic [1:0]          w_last_idx;
    logic [32:0]         w_end_addr;
    logic                w_range_err;
    logic                w_f3_err;
    logic                w_mis_err;
    logic                w_req_err;
    logic [1:0]          w_cap_idx;
    logic [7:0]          w_beat_byte;
    logic                w_sign;
    logic [31:0]         w_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Index of the final beat: 0/1/3 for byte/half/word.
    always_comb begin
        w_last_idx = 2'd3;
        case (req_func3[1:0])
            2'b00:   w_last_idx = 2'd0;
            2'b01:   w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    // Range check widened to 33 bits so an address near 2**32 cannot wrap
    // around and appear to be in range.
    assign w_end_addr  = {1'b0, req_addr} + 33'(w_last_idx) + 33'd1;
    assign w_range_err = (w_end_addr > 33'(DEPTH));

    always_comb begin
        w_f3_err = 1'b1;
        if (req_we) begin
            w_f3_err = (req_func3 > 3'b010);
        end else begin
            case (req_func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_err = 1'b0;
                default:                                w_f3_err = 1'b1;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_mis_err = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_mis_err = 1'b0;
`endif

    assign w_req_err = w_f3_err || w_range_err || w_mis_err;

    // A read byte arrives one cycle after its beat, so in BEAT we capture the
    // previous beat's byte, and LAST picks up the final one.
    assign w_cap_idx = (r_state == S_LAST) ? r_last_idx : (r_idx - 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_idx      <= 2'd0;
            r_last_idx <= 2'd0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we       <= req_we;
                r_func3    <= req_func3;
                r_addr     <= req_addr[ADDR_W-1:0];
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
                r_idx      <= 2'd0;
                r_last_idx <= w_last_idx;
                r_rdata    <= 32'h0;
            end else if ((r_state == S_LAST) ||
                         ((r_state == S_BEAT) && !r_we && (r_idx != 2'd0))) begin
                if (r_state == S_BEAT) begin
                    r_idx <= r_idx + 2'd1;
                end
                case (w_cap_idx)
                    2'd0:    r_rdata[7:0]   <= mem_rdata;
                    2'd1:    r_rdata[15:8]  <= mem_rdata;
                    2'd2:    r_rdata[23:16] <= mem_rdata;
                    default: r_rdata[31:24] <= mem_rdata;
                endcase
            end else if (r_state == S_BEAT) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    always_comb begin
        w_beat_byte = r_wdata[7:0];
        case (r_idx)
            2'd0:    w_beat_byte = r_wdata[7:0];
            2'd1:    w_beat_byte = r_wdata[15:8];
            2'd2:    w_beat_byte = r_wdata[23:16];
            default: w_beat_byte = r_wdata[31:24];
        endcase
    end

    // funct3[2] set means the unsigned variant (LBU/LHU).
    assign w_sign = ~r_func3[2];

    always_comb begin
        w_ext = r_rdata;
        case (r_func3[1:0])
            2'b00:   w_ext = {{24{w_sign & r_rdata[7]}},  r_rdata[7:0]};
            2'b01:   w_ext = {{16{w_sign & r_rdata[15]}}, r_rdata[15:0]};
            default: w_ext = r_rdata;
        endcase
    end

    // Outputs are decoded from registered state, so an asynchronous reset
    // drops mem_en immediately.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_req_err ? S_RESP : S_BEAT;
                end
            end
            S_BEAT: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr + ADDR_W'(r_idx);
                mem_wdata = w_beat_byte;
                if (r_idx == r_last_idx) begin
                    w_next = r_we ? S_RESP : S_LAST;
                end
            end
            S_LAST: begin
                w_next = S_RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_err || r_we) ? 32'h0 : w_ext;
                w_next    = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
